// File: rtl/fact_bus_if.sv
// Data-memory bus slice seen by the factorial accelerator: decoded write strobe,
// register select, write data and combinational read data.
interface fact_bus_if #(
  parameter int unsigned WIDTH = 32
);
  logic             we;
  logic [1:0]       a;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] rd;

  modport master (output we, output a, output wd, input rd);
  modport slave  (input we, input a, input wd, output rd);
endinterface

// File: rtl/fact_accel.sv
// Memory-mapped factorial accelerator. Software writes N, then toggles GO 0->1;
// an iterative multiply FSM computes N! and exposes STATUS/RESULT on the read mux.
// Optional feature macro: FACT_IRQ_EN adds irq_o, a one-cycle pulse per DONE entry.
module fact_accel #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N_W   = 4,
  parameter int unsigned MAX_N = 12
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef FACT_IRQ_EN
  output logic       irq_o,
`endif
  fact_bus_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e           state_q;
  logic [N_W-1:0]   n_q;
  logic             go_q;
  logic [N_W-1:0]   cnt_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] result_q;
  logic             done_q;
  logic             err_q;
`ifdef FACT_IRQ_EN
  logic             irq_q;
`endif

  logic             n_wr;
  logic             go_wr;
  logic             start;
  logic             n_too_big;
  logic [WIDTH-1:0] prod;

  // Decode bus writes; only a 0->1 edge of GO starts a computation.
  always_comb begin
    n_wr      = bus.we && (bus.a == 2'd0) && (state_q != StCalc);
    go_wr     = bus.we && (bus.a == 2'd1);
    start     = go_wr && bus.wd[0] && !go_q;
    n_too_big = int'(n_q) > int'(MAX_N);
    prod      = acc_q * WIDTH'(cnt_q);
  end

  // N and GO registers; N is frozen while a computation is running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q  <= '0;
      go_q <= 1'b0;
    end else begin
      if (n_wr) n_q <= bus.wd[N_W-1:0];
      if (go_wr) go_q <= bus.wd[0];
    end
  end

  // Control FSM with registered status/result; result only updates on DONE entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef FACT_IRQ_EN
      irq_q    <= 1'b0;
`endif
    end else begin
`ifdef FACT_IRQ_EN
      irq_q <= 1'b0;
`endif
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            if (n_too_big) begin
              state_q  <= StDone;
              err_q    <= 1'b1;
              done_q   <= 1'b1;
              result_q <= '0;
`ifdef FACT_IRQ_EN
              irq_q    <= 1'b1;
`endif
            end else begin
              state_q <= StCalc;
              cnt_q   <= n_q;
              acc_q   <= WIDTH'(1);
              done_q  <= 1'b0;
              err_q   <= 1'b0;
            end
          end
        end
        StCalc: begin
          if (cnt_q > N_W'(1)) begin
            acc_q <= prod;
            cnt_q <= cnt_q - N_W'(1);
          end else begin
            state_q  <= StDone;
            result_q <= acc_q;
            done_q   <= 1'b1;
`ifdef FACT_IRQ_EN
            irq_q    <= 1'b1;
`endif
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Combinational read mux; reads have no side effects.
  always_comb begin
    bus.rd = '0;
    unique case (bus.a)
      2'd0: bus.rd[N_W-1:0] = n_q;
      2'd1: bus.rd[0]       = go_q;
      2'd2: bus.rd[1:0]     = {err_q, done_q};
      2'd3: bus.rd          = result_q;
      default: bus.rd = '0;
    endcase
  end

`ifdef FACT_IRQ_EN
  assign irq_o = irq_q;
`endif

endmodule
